// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared state encoding and access-type constants for the LC-3 memory controller
package lc3_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/lc3_reg.sv
// rtl/lc3_reg.sv - WIDTH-bit register with load enable and synchronous reset (MAR / MDR)
module lc3_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 MAR/MDR memory access controller (IDLE/ACCESS/DONE)
// Optional access timeout with error pulse: define LC3_MEM_TIMEOUT_EN.
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ld_mar,
   input  logic             ld_mdr,
   input  logic             mio_en,
   input  logic             r_w,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_req,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic [WIDTH-1:0] mdr_out,
   output logic             ready,
   output logic             busy,
   output logic             mem_err
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("lc3_mem_ctrl: TIMEOUT must be in 1..255");
   end

   state_t           state;
   logic [WIDTH-1:0] mar_q;
   logic [WIDTH-1:0] mdr_q;
   logic             mar_ld;
   logic             mdr_ld;
   logic [WIDTH-1:0] mdr_d;

   // Bus loads only in IDLE; a read completion is the only other way into MDR.
   assign mar_ld = (state == IDLE) && ld_mar;
   assign mdr_ld = ((state == IDLE) && ld_mdr) ||
                   ((state == ACCESS) && mem_ack && (mem_we == MEM_READ));
   assign mdr_d  = (state == ACCESS) ? mem_rdata : bus_in;

   lc3_reg #(.WIDTH(WIDTH)) u_mar (
      .clk (clk),
      .rst (rst),
      .ld  (mar_ld),
      .d   (bus_in),
      .q   (mar_q)
   );

   lc3_reg #(.WIDTH(WIDTH)) u_mdr (
      .clk (clk),
      .rst (rst),
      .ld  (mdr_ld),
      .d   (mdr_d),
      .q   (mdr_q)
   );

   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign mdr_out   = mdr_q;
   assign busy      = (state != IDLE);

`ifdef LC3_MEM_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       err_q;
   assign mem_err = err_q;
`else
   assign mem_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         ready   <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
         err_q    <= 1'b0;
         wait_cnt <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               if (mio_en) begin
                  state   <= ACCESS;
                  mem_req <= 1'b1;
                  mem_we  <= r_w;
`ifdef LC3_MEM_TIMEOUT_EN
                  wait_cnt <= 8'd0;
`endif
               end
            end
            ACCESS: begin
               // An ack in the cycle the count would expire still completes normally.
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  ready   <= 1'b1;
               end
`ifdef LC3_MEM_TIMEOUT_EN
               else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt + 8'd1 == TIMEOUT[7:0]) begin
                     state   <= DONE;
                     mem_req <= 1'b0;
                     mem_we  <= 1'b0;
                     ready   <= 1'b1;
                     err_q   <= 1'b1;
                  end
               end
`endif
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
               err_q <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles before an access is aborted; legal range 1..255.
REQ-003 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  datapath bus value (selected upstream by the ADDR/MAR/MIO muxes).
- ld_mar  input  1  load MAR from bus_in.
- ld_mdr  input  1  load MDR from bus_in.
- mio_en  input  1  start a memory access.
- r_w  input  1  access type: 0 = read, 1 = write; sampled at start.
- mem_addr  output  WIDTH  memory address, always equal to MAR.
- mem_wdata  output  WIDTH  write data, always equal to MDR.
- mem_req  output  1  access request to memory.
- mem_we  output  1  write enable, qualified by mem_req.
- mem_rdata  input  WIDTH  read data from memory.
- mem_ack  input  1  memory completion strobe.
- mdr_out  output  WIDTH  MDR value, fed to the gate-MDR bus mux.
- ready  output  1  the LC-3 R signal; one-cycle pulse when an access completes.
- busy  output  1  high while state is not IDLE.
- mem_err  output  1  one-cycle pulse when an access times out (0 when the timeout feature is compiled out).

Function
REQ-004 SHALL implement a state machine with states IDLE, ACCESS and DONE.
REQ-005 In IDLE, ld_mar SHALL load MAR with bus_in at the next edge, and ld_mdr SHALL load MDR with bus_in at the next edge.
REQ-006 In IDLE with mio_en=1, the block SHALL go to ACCESS at the next edge, latch r_w into mem_we, and register mem_req=1, so mem_req is high 1 cycle after mio_en.
REQ-007 If ld_mar or ld_mdr is high in the same IDLE cycle as mio_en, the loads SHALL take effect first, and the access SHALL use the newly loaded values.
REQ-008 In ACCESS, mem_req SHALL stay high and mem_addr, mem_wdata and mem_we SHALL stay stable until mem_ack is sampled high.
REQ-009 mem_ack sampled high in ACCESS SHALL cause the following at the same edge:
- mem_req drops;
- the state moves to DONE;
- on a read, MDR loads mem_rdata;
- ready is 1 in the DONE cycle.
REQ-010 A zero-wait access, with mem_ack high in the first ACCESS cycle, SHALL be accepted, giving mio_en to ready in 2 cycles.
REQ-011 DONE SHALL last exactly 1 cycle and then return to IDLE.
REQ-012 While busy, mio_en, ld_mar and ld_mdr SHALL be ignored.
REQ-013 mem_ack SHALL be ignored in IDLE and DONE.
REQ-014 ready, mem_req and mem_err SHALL be registered outputs with no combinational path from any input.

Reset
REQ-015 When rst is high at an edge, the block SHALL set the state to IDLE, MAR=0, MDR=0, mem_req=0, mem_we=0, ready=0, mem_err=0 and the wait counter to 0.
REQ-016 rst SHALL take priority over all other inputs.
REQ-017 rst during ACCESS SHALL abandon the access with no ready pulse, and mem_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-018 With macro LC3_MEM_TIMEOUT_EN defined:
- an 8-bit counter SHALL count the ACCESS cycles in which mem_ack is low;
- when the count reaches TIMEOUT, the block SHALL drop mem_req, leave MDR unchanged, and go to DONE with ready=1 and mem_err=1 for that one cycle;
- mem_ack arriving in the same cycle as the count reaches TIMEOUT SHALL win, completing the access normally with no error.
REQ-019 Without LC3_MEM_TIMEOUT_EN, no counter SHALL be built, mem_err SHALL be tied to 0, and ACCESS SHALL wait indefinitely for mem_ack.

Structure
REQ-020 A shared package lc3_pkg SHALL hold the state enumeration, the MEM_READ=0 and MEM_WRITE=1 constants, and the default WIDTH.
REQ-021 One sub-module lc3_reg, a WIDTH-bit register with load enable and synchronous reset, SHALL be instantiated twice, for MAR and MDR.
REQ-022 The complete implementation SHALL be a single file of about 150-250 lines.

Verification
REQ-023 Reset: hold rst for 2 cycles with mio_en=1 -> mem_req=0, ready=0, mdr_out=0x0000, busy=0.
REQ-024 Read with zero wait: ld_mar with bus=0x3000, then mio_en with r_w=0, then mem_ack in the first ACCESS cycle with rdata=0xBEEF -> mem_addr=0x3000, ready high 2 cycles after mio_en, mdr_out=0xBEEF.
REQ-025 Write with 3 wait cycles: MAR=0xFE06, MDR=0x0041, r_w=1 -> mem_req and mem_we high for 4 cycles, mem_wdata=0x0041 throughout, ready pulses once, MDR unchanged.
REQ-026 Busy lockout: pulse ld_mdr with bus=0x1234 mid-ACCESS, and pulse mio_en in DONE -> MDR not loaded from the bus and no second access started.
REQ-027 Timeout (macro defined, TIMEOUT=4): mem_ack never arrives -> mem_req drops after 4 cycles, then ready=1 and mem_err=1 together for 1 cycle; a second run with ack on the 4th cycle -> mem_err=0.
REQ-028 Reset mid-access: assert rst in the 2nd ACCESS cycle -> mem_req=0 in the next cycle, no ready pulse, state IDLE.
